fb_mem_arbiter: RTL and testbench

// - Shares the single-port FB-CPU program/data RAM between two masters: the FBCPU core (M0) and a

---
 rtl/fbcpu_pkg.sv | 15 +
 rtl/fb_mem_arbiter_if.sv | 25 ++
 rtl/fb_rr_arb2.sv | 24 ++
 rtl/fb_mem_arbiter.sv | 87 ++++++++
 tb/tb_fb_mem_arbiter.sv | 154 +++++++++++++++
 5 files changed

// File: rtl/fbcpu_pkg.sv
// Shared constants for the FB-CPU memory subsystem: default RAM geometry,
// master ids and the bound on the starvation-guard counter.
package fbcpu_pkg;

  localparam int DEF_ADDRESS_WIDTH = 6;
  localparam int DEF_DATA_WIDTH    = 10;
  localparam int WAIT_CNT_W        = 4;
  localparam int MAX_WAIT_LIMIT    = 15;

  typedef enum logic {
    MST_CPU = 1'b0,
    MST_LDR = 1'b1
  } mst_id_e;

endpackage

// File: rtl/fb_mem_arbiter_if.sv
// One master's request/grant/read-return channel into the RAM arbiter.
interface fb_mem_arbiter_if #(
  parameter int ADDRESS_WIDTH = 6,
  parameter int DATA_WIDTH    = 10
);

  logic                     req;
  logic                     we;
  logic [ADDRESS_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0]    wdata;
  logic                     gnt;
  logic                     rvalid;
  logic [DATA_WIDTH-1:0]    rdata;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/fb_rr_arb2.sv
// Two-way arbiter: round-robin on last_gnt, or M0 priority with a starvation
// override that hands one cycle to M1.
module fb_rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_gnt,
  input  logic       fixed,
  input  logic       starve,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b01: gnt = 2'b01;
      2'b10: gnt = 2'b10;
      2'b11: begin
        if (fixed) gnt = starve ? 2'b10 : 2'b01;
        else       gnt = last_gnt ? 2'b01 : 2'b10;
      end
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/fb_mem_arbiter.sv
// Shares the single-port FB-CPU RAM between the core (M0) and the loader/debug
// port (M1); combinational address path, one-cycle read return to the issuer.
module fb_mem_arbiter
  import fbcpu_pkg::*;
#(
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter bit FIXED_PRIO    = 1'b0,
  parameter int MAX_WAIT      = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  fb_mem_arbiter_if.slave          m0,
  fb_mem_arbiter_if.slave          m1,
  output logic [ADDRESS_WIDTH-1:0] ram_addr,
  output logic                     ram_we,
  output logic [DATA_WIDTH-1:0]    ram_wdata,
  input  logic [DATA_WIDTH-1:0]    ram_rdata
);

  localparam logic [WAIT_CNT_W-1:0] MAX_WAIT_C = WAIT_CNT_W'(MAX_WAIT);

  logic [1:0]            req;
  logic [1:0]            gnt_raw;
  logic [1:0]            gnt;
  logic                  starve;
  mst_id_e               last_gnt;
  mst_id_e               rd_src;
  logic                  rd_pend;
  logic [WAIT_CNT_W-1:0] wait_cnt;

  assign req    = {m1.req, m0.req};
  assign starve = FIXED_PRIO && (wait_cnt == MAX_WAIT_C);

  fb_rr_arb2 u_arb (
    .req      (req),
    .last_gnt (last_gnt == MST_LDR),
    .fixed    (FIXED_PRIO),
    .starve   (starve),
    .gnt      (gnt_raw)
  );

  assign gnt    = rst ? 2'b00 : gnt_raw;
  assign m0.gnt = gnt[0];
  assign m1.gnt = gnt[1];

  always_comb begin
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = '0;
    if (gnt[0]) begin
      ram_addr  = m0.addr;
      ram_we    = m0.we;
      ram_wdata = m0.wdata;
    end else if (gnt[1]) begin
      ram_addr  = m1.addr;
      ram_we    = m1.we;
      ram_wdata = m1.wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt <= MST_LDR;
      wait_cnt <= '0;
      rd_pend  <= 1'b0;
      rd_src   <= MST_CPU;
    end else begin
      if (|gnt) begin
        last_gnt <= gnt[1] ? MST_LDR : MST_CPU;
        rd_src   <= gnt[1] ? MST_LDR : MST_CPU;
      end
      rd_pend <= (gnt[0] && !m0.we) || (gnt[1] && !m1.we);
      if (!m1.req || gnt[1])
        wait_cnt <= '0;
      else if (wait_cnt != MAX_WAIT_C)
        wait_cnt <= wait_cnt + WAIT_CNT_W'(1);
    end
  end

  // rst gates rvalid directly so a read pending across reset never surfaces
  assign m0.rvalid = rd_pend && !rst && (rd_src == MST_CPU);
  assign m1.rvalid = rd_pend && !rst && (rd_src == MST_LDR);
  assign m0.rdata  = m0.rvalid ? ram_rdata : '0;
  assign m1.rdata  = m1.rvalid ? ram_rdata : '0;

endmodule

// File: tb/tb_fb_mem_arbiter.sv
// Directed bench for fb_mem_arbiter: round-robin and fixed-priority instances,
// each with a write-first synchronous RAM model preloaded with mem[i] = 3*i+1.
module tb_fb_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic load = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  fb_mem_arbiter_if #(.ADDRESS_WIDTH(6), .DATA_WIDTH(10)) rr_m0 ();
  fb_mem_arbiter_if #(.ADDRESS_WIDTH(6), .DATA_WIDTH(10)) rr_m1 ();
  fb_mem_arbiter_if #(.ADDRESS_WIDTH(6), .DATA_WIDTH(10)) fp_m0 ();
  fb_mem_arbiter_if #(.ADDRESS_WIDTH(6), .DATA_WIDTH(10)) fp_m1 ();

  logic [5:0] rr_ram_addr, fp_ram_addr;
  logic       rr_ram_we, fp_ram_we;
  logic [9:0] rr_ram_wdata, fp_ram_wdata, rr_ram_rdata, fp_ram_rdata;
  logic [9:0] rr_mem [64];
  logic [9:0] fp_mem [64];

  fb_mem_arbiter #(.ADDRESS_WIDTH(6), .DATA_WIDTH(10), .FIXED_PRIO(1'b0), .MAX_WAIT(4)) dut_rr (
    .clk(clk), .rst(rst), .m0(rr_m0), .m1(rr_m1),
    .ram_addr(rr_ram_addr), .ram_we(rr_ram_we), .ram_wdata(rr_ram_wdata), .ram_rdata(rr_ram_rdata)
  );

  fb_mem_arbiter #(.ADDRESS_WIDTH(6), .DATA_WIDTH(10), .FIXED_PRIO(1'b1), .MAX_WAIT(4)) dut_fp (
    .clk(clk), .rst(rst), .m0(fp_m0), .m1(fp_m1),
    .ram_addr(fp_ram_addr), .ram_we(fp_ram_we), .ram_wdata(fp_ram_wdata), .ram_rdata(fp_ram_rdata)
  );

  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 64; i++) begin
        rr_mem[i] <= 10'(3 * i + 1);
        fp_mem[i] <= 10'(3 * i + 1);
      end
      rr_ram_rdata <= '0;
      fp_ram_rdata <= '0;
    end else begin
      if (rr_ram_we) rr_mem[rr_ram_addr] <= rr_ram_wdata;
      if (fp_ram_we) fp_mem[fp_ram_addr] <= fp_ram_wdata;
      rr_ram_rdata <= rr_ram_we ? rr_ram_wdata : rr_mem[rr_ram_addr];
      fp_ram_rdata <= fp_ram_we ? fp_ram_wdata : fp_mem[fp_ram_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r0, input logic w0, input logic [5:0] a0, input logic [9:0] d0,
                       input logic r1, input logic w1, input logic [5:0] a1, input logic [9:0] d1);
    rr_m0.req = r0; rr_m0.we = w0; rr_m0.addr = a0; rr_m0.wdata = d0;
    rr_m1.req = r1; rr_m1.we = w1; rr_m1.addr = a1; rr_m1.wdata = d1;
  endtask

  initial begin
    drive(1'b1, 1'b0, 6'd5, 10'h0, 1'b1, 1'b0, 6'd9, 10'h0);
    fp_m0.req = 1'b1; fp_m0.we = 1'b0; fp_m0.addr = 6'd1; fp_m0.wdata = '0;
    fp_m1.req = 1'b1; fp_m1.we = 1'b0; fp_m1.addr = 6'd2; fp_m1.wdata = '0;

    // reset held with both masters requesting
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst_gnt", {rr_m1.gnt, rr_m0.gnt, fp_m1.gnt, fp_m0.gnt}, 4'b0000);
      chk("rst_ram", {rr_ram_we, rr_ram_addr, fp_ram_we, fp_ram_addr}, 14'h0);
      chk("rst_rvalid", {rr_m0.rvalid, rr_m1.rvalid, fp_m0.rvalid, fp_m1.rvalid}, 4'b0000);
      next_cycle();
    end
    rst = 1'b0;
    load = 1'b0;

    // contention on both instances: RR alternates, fixed gives M0 x4 then M1 x1
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("rr_gnt", {rr_m1.gnt, rr_m0.gnt}, (k % 2 == 0) ? 2'b01 : 2'b10);
      chk("rr_addr", rr_ram_addr, (k % 2 == 0) ? 6'd5 : 6'd9);
      if (k > 0) begin
        chk("rr_m0_rv", {rr_m0.rvalid, rr_m0.rdata}, (k % 2 == 1) ? {1'b1, 10'd16} : 11'h0);
        chk("rr_m1_rv", {rr_m1.rvalid, rr_m1.rdata}, (k % 2 == 0) ? {1'b1, 10'd28} : 11'h0);
      end
      chk("fp_gnt", {fp_m1.gnt, fp_m0.gnt}, (k % 5 == 4) ? 2'b10 : 2'b01);
      chk("fp_addr", fp_ram_addr, (k % 5 == 4) ? 6'd2 : 6'd1);
      chk("fp_wcnt_le4", dut_fp.wait_cnt <= 4'd4, 1'b1);
      next_cycle();
    end
    fp_m0.req = 1'b0;
    fp_m1.req = 1'b0;

    // M1 writes 0x2A5 @3, M0 reads @3 the next cycle
    drive(1'b0, 1'b0, 6'd0, 10'h0, 1'b1, 1'b1, 6'd3, 10'h2A5);
    @(negedge clk);
    chk("wr_gnt", {rr_m1.gnt, rr_m0.gnt}, 2'b10);
    chk("wr_ram", {rr_ram_we, rr_ram_addr, rr_ram_wdata}, {1'b1, 6'd3, 10'h2A5});
    next_cycle();
    drive(1'b1, 1'b0, 6'd3, 10'h0, 1'b0, 1'b0, 6'd0, 10'h0);
    @(negedge clk);
    chk("rd_gnt", {rr_m1.gnt, rr_m0.gnt, rr_ram_we}, 3'b010);
    chk("rd_addr", rr_ram_addr, 6'd3);
    next_cycle();
    drive(1'b0, 1'b0, 6'd0, 10'h0, 1'b0, 1'b0, 6'd0, 10'h0);
    @(negedge clk);
    chk("wr_rd_m0", {rr_m0.rvalid, rr_m0.rdata}, {1'b1, 10'h2A5});
    chk("wr_rd_m1", {rr_m1.rvalid, rr_m1.rdata}, 11'h0);
    next_cycle();

    // idle: outputs quiet, last_gnt (M0) must survive
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("idle_ram", {rr_ram_we, rr_ram_addr, rr_ram_wdata}, 17'h0);
      chk("idle_rv", {rr_m0.rvalid, rr_m1.rvalid, rr_m0.gnt, rr_m1.gnt}, 4'b0000);
      next_cycle();
    end
    drive(1'b1, 1'b0, 6'd7, 10'h0, 1'b1, 1'b0, 6'd8, 10'h0);
    @(negedge clk);
    chk("post_idle_gnt", {rr_m1.gnt, rr_m0.gnt}, 2'b10);
    next_cycle();

    // reset while a read is pending
    drive(1'b1, 1'b0, 6'd5, 10'h0, 1'b0, 1'b0, 6'd0, 10'h0);
    @(negedge clk);
    chk("mid_gnt", {rr_m1.gnt, rr_m0.gnt}, 2'b01);
    next_cycle();
    rst = 1'b1;
    drive(1'b0, 1'b0, 6'd0, 10'h0, 1'b0, 1'b0, 6'd0, 10'h0);
    @(negedge clk);
    chk("mid_rst_rv", {rr_m0.rvalid, rr_m0.rdata}, 11'h0);
    next_cycle();
    rst = 1'b0;
    drive(1'b1, 1'b0, 6'd4, 10'h0, 1'b1, 1'b0, 6'd6, 10'h0);
    @(negedge clk);
    chk("post_rst_rv", {rr_m0.rvalid, rr_m1.rvalid}, 2'b00);
    chk("post_rst_gnt", {rr_m1.gnt, rr_m0.gnt}, 2'b01);
    next_cycle();
    @(negedge clk);
    chk("post_rst_rd", {rr_m0.rvalid, rr_m0.rdata, rr_m1.gnt}, {1'b1, 10'd13, 1'b1});

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
